axi4lite_master_bridge: RTL and testbench

- Initiator end of the AXI4-Lite link: converts single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions, and returns the result on a valid/ready response port.
- Drives the master-side signals of axi4lite_if; used by the CPU/DFT test driver to reach the AXI4-Lite slave memory.
- One transaction outstanding at a time.

---
 rtl/axi4lite_pkg.sv | 23 ++
 rtl/axi4lite_master_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4lite_master_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite types: response codes, bridge FSM states and default widths.
package axi4lite_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 6;
    localparam int unsigned AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } master_state_t;

endpackage

// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator behind a valid/ready command/response port.
// Optional AXI4LITE_MASTER_ALIGN_CHECK_EN answers misaligned commands locally with SLVERR.
module axi4lite_master_bridge
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic                  BVALID,
    input  logic [1:0]            BRESP,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic                  RVALID,
    input  logic [1:0]            RRESP,
    input  logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RREADY
);

    master_state_t         state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t                 rsp_resp_q, rsp_resp_d;
    logic                  misaligned_s;
    logic                  aw_done_s;
    logic                  w_done_s;

`ifdef AXI4LITE_MASTER_ALIGN_CHECK_EN
    localparam int unsigned ALIGN_LSB = $clog2(STRB_WIDTH);
    assign misaligned_s = (cmd_addr[ALIGN_LSB-1:0] != '0);
`else
    assign misaligned_s = 1'b0;
`endif

    // A write channel counts as done once its VALID has dropped or is being accepted now.
    assign aw_done_s = !awvalid_q || AWREADY;
    assign w_done_s  = !wvalid_q  || WREADY;

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rsp_write_d = cmd_write;
                    if (misaligned_s) begin
                        rsp_resp_d  = SLVERR;
                        rsp_rdata_d = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RSP;
                    end else if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (WREADY) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_s && w_done_s) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = resp_t'(BRESP);
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_DATA: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = resp_t'(RRESP);
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    state_d = RD_DATA;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWADDR    = addr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge with a small behavioural AXI4-Lite slave
// whose ready/response latencies are adjustable per scenario.
module tb_axi4lite_master_bridge;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [5:0]  AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;

    // slave knobs and state
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    int          aw_hs_cnt = 0, w_hs_cnt = 0;
    logic [5:0]  err_addr = 6'h3C;
    logic        aw_got, w_got, r_pend;
    logic [5:0]  aw_a, r_a, wa;
    logic [31:0] w_d, wd;
    logic [3:0]  w_s, ws;
    logic [31:0] mem [16];
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r, rresp_r;
    logic [31:0] rdata_r;
    logic        aw_hs, w_hs, ar_hs, have_aw, have_w;

    axi4lite_master_bridge dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RVALID(RVALID), .RRESP(RRESP), .RDATA(RDATA), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    assign AWREADY = (aw_cnt >= aw_lat);
    assign WREADY  = (w_cnt >= w_lat);
    assign ARREADY = (ar_cnt >= ar_lat);
    assign BVALID  = bvalid_r;
    assign BRESP   = bresp_r;
    assign RVALID  = rvalid_r;
    assign RRESP   = rresp_r;
    assign RDATA   = rdata_r;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign have_aw = aw_got || aw_hs;
    assign have_w  = w_got || w_hs;
    assign wa      = aw_got ? aw_a : AWADDR;
    assign wd      = w_got ? w_d : WDATA;
    assign ws      = w_got ? w_s : WSTRB;

    // Behavioural slave: ready counters, write memory, B and R responses.
    always @(posedge ACLK) begin
        aw_hs_cnt <= aw_hs_cnt + (aw_hs ? 1 : 0);
        w_hs_cnt  <= w_hs_cnt + (w_hs ? 1 : 0);
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            aw_a <= 6'h0; r_a <= 6'h0; w_d <= 32'h0; w_s <= 4'h0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00;
            rresp_r <= 2'b00; rdata_r <= 32'h0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1; else if (aw_hs) aw_cnt <= 0;
            if (WVALID && !WREADY) w_cnt <= w_cnt + 1; else if (w_hs) w_cnt <= 0;
            if (ARVALID && !ARREADY) ar_cnt <= ar_cnt + 1; else if (ar_hs) ar_cnt <= 0;
            if (BVALID && BREADY) bvalid_r <= 1'b0;
            if (have_aw && have_w) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                bvalid_r <= 1'b1;
                if (wa == err_addr) begin
                    bresp_r <= 2'b10;
                end else begin
                    bresp_r <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) mem[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
                end
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_a <= AWADDR; end
                if (w_hs) begin w_got <= 1'b1; w_d <= WDATA; w_s <= WSTRB; end
            end
            if (RVALID && RREADY) rvalid_r <= 1'b0;
            if (ar_hs) begin
                r_a <= ARADDR;
                if (r_lat == 0) begin
                    rvalid_r <= 1'b1;
                    rdata_r  <= mem[ARADDR[5:2]];
                    rresp_r  <= (ARADDR == err_addr) ? 2'b11 : 2'b00;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= 1;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_lat) begin
                    rvalid_r <= 1'b1;
                    rdata_r  <= mem[r_a[5:2]];
                    rresp_r  <= (r_a == err_addr) ? 2'b11 : 2'b00;
                    r_pend   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // Present a command and return just after the accepting edge (edge N).
    task automatic send_cmd(input logic w, input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    // Called at the negedge where rsp_valid is first seen; stalls, then consumes.
    task automatic finish_rsp(input string name, input logic exp_w, input logic [31:0] exp_d,
                              input logic [1:0] exp_r, input int hold);
        checks++;
        if ({rsp_write, rsp_rdata, rsp_resp} !== {exp_w, exp_d, exp_r}) begin
            errors++;
            $display("FAIL %s rsp: got w=%b d=%h r=%b required w=%b d=%h r=%b",
                     name, rsp_write, rsp_rdata, rsp_resp, exp_w, exp_d, exp_r);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            checks++;
            if ({rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp} !==
                {1'b1, 1'b0, exp_w, exp_d, exp_r}) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%b crdy=%b d=%h r=%b required v=1 crdy=0 d=%h r=%b",
                         name, h, rsp_valid, cmd_ready, rsp_rdata, rsp_resp, exp_d, exp_r);
            end
        end
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1 rsp_ready = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s release: got rsp_valid=%b cmd_ready=%b required 0 1",
                     name, rsp_valid, cmd_ready);
        end
    endtask

    // Write scenario: j counts negedges after the accept edge; rsp_valid due at j == tot.
    task automatic do_write_seq(input string name, input logic [5:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int aw_end, input int w_end,
                                input int tot, input logic [1:0] exp_r, input int hold);
        logic [4:0] exp_v;
        send_cmd(1'b1, a, d, s);
        for (int j = 1; j <= tot; j++) begin
            @(negedge ACLK);
            exp_v = {(j <= aw_end), (j <= w_end), (j == tot - 1), (j == tot), 1'b0};
            checks++;
            if ({AWVALID, WVALID, BREADY, rsp_valid, cmd_ready} !== exp_v) begin
                errors++;
                $display("FAIL %s j=%0d {awv,wv,brdy,rspv,crdy}: got %b required %b", name, j,
                         {AWVALID, WVALID, BREADY, rsp_valid, cmd_ready}, exp_v);
            end
            if (j <= aw_end) begin
                checks++;
                if (AWADDR !== a) begin
                    errors++;
                    $display("FAIL %s j=%0d awaddr: got %h required %h", name, j, AWADDR, a);
                end
            end
            if (j <= w_end) begin
                checks++;
                if ({WDATA, WSTRB} !== {d, s}) begin
                    errors++;
                    $display("FAIL %s j=%0d wpayload: got %h/%h required %h/%h", name, j,
                             WDATA, WSTRB, d, s);
                end
            end
        end
        finish_rsp(name, 1'b1, 32'h0, exp_r, hold);
    endtask

    // Read scenario with zero-wait ARREADY; rsp_valid due at j == rsp_at (3 + RVALID delay).
    task automatic do_read_seq(input string name, input logic [5:0] a, input logic [31:0] exp_d,
                               input logic [1:0] exp_r, input int rsp_at, input int hold);
        logic [4:0] exp_v;
        send_cmd(1'b0, a, 32'h0, 4'h0);
        for (int j = 1; j <= rsp_at; j++) begin
            @(negedge ACLK);
            exp_v = {(j == 1), (j > 1 && j < rsp_at), (j == rsp_at), 1'b0, 1'b0};
            checks++;
            if ({ARVALID, RREADY, rsp_valid, cmd_ready, AWVALID} !== exp_v) begin
                errors++;
                $display("FAIL %s j=%0d {arv,rrdy,rspv,crdy,awv}: got %b required %b", name, j,
                         {ARVALID, RREADY, rsp_valid, cmd_ready, AWVALID}, exp_v);
            end
            if (j == 1) begin
                checks++;
                if (ARADDR !== a) begin
                    errors++;
                    $display("FAIL %s araddr: got %h required %h", name, ARADDR, a);
                end
            end
        end
        finish_rsp(name, 1'b0, exp_d, exp_r, hold);
    endtask

    task automatic test_reset();
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000001",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready});
        end
        checks++;
        if ({AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {AWADDR, WDATA, WSTRB, rsp_rdata, rsp_resp});
        end
        ARESET = 1'b0;
    endtask

    task automatic test_write_basic();
        do_write_seq("wr_basic", 6'h08, 32'hDEADBEEF, 4'hF, 1, 1, 3, 2'b00, 0);
        do_read_seq("rd_basic", 6'h08, 32'hDEADBEEF, 2'b00, 3, 0);
    endtask

    task automatic test_aw_w_skew();
        aw_lat = 1; w_lat = 4;
        do_write_seq("wr_aw_first", 6'h14, 32'hCAFEF00D, 4'hF, 2, 5, 7, 2'b00, 0);
        aw_lat = 4; w_lat = 1;
        do_write_seq("wr_w_first", 6'h18, 32'h0BADC0DE, 4'hF, 5, 2, 7, 2'b00, 1);
        aw_lat = 0; w_lat = 0;
        do_read_seq("rd_skew_a", 6'h14, 32'hCAFEF00D, 2'b00, 3, 0);
        do_read_seq("rd_skew_b", 6'h18, 32'h0BADC0DE, 2'b00, 3, 0);
    endtask

    task automatic test_read_wait();
        r_lat = 5;
        do_read_seq("rd_wait", 6'h08, 32'hDEADBEEF, 2'b00, 8, 2);
        r_lat = 0;
    endtask

    task automatic test_slverr();
        int aw0, w0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        do_write_seq("wr_slverr", 6'h3C, 32'h12345678, 4'hF, 1, 1, 3, 2'b10, 0);
        repeat (4) @(negedge ACLK);
        checks++;
        if ((aw_hs_cnt - aw0) != 1 || (w_hs_cnt - w0) != 1 || AWVALID !== 1'b0) begin
            errors++;
            $display("FAIL slverr_no_retry: got aw_hs=%0d w_hs=%0d awv=%b required 1 1 0",
                     aw_hs_cnt - aw0, w_hs_cnt - w0, AWVALID);
        end
        do_read_seq("rd_decerr", 6'h3C, 32'h0, 2'b11, 3, 0);
    endtask

    task automatic test_strobe();
        do_write_seq("wr_strb", 6'h10, 32'h11223344, 4'b0101, 1, 1, 3, 2'b00, 0);
        do_read_seq("rd_strb", 6'h10, 32'h00220044, 2'b00, 3, 0);
    endtask

    task automatic test_reset_mid();
        ar_lat = 20;
        send_cmd(1'b0, 6'h08, 32'h0, 4'h0);
        for (int j = 1; j <= 2; j++) begin
            @(negedge ACLK);
            checks++;
            if ({ARVALID, ARADDR} !== {1'b1, 6'h08}) begin
                errors++;
                $display("FAIL rst_mid_hold j=%0d: got arv=%b araddr=%h required 1 08",
                         j, ARVALID, ARADDR);
            end
        end
        ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        ar_lat = 0;
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b required 0000001",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready});
        end
        do_write_seq("wr_after_rst", 6'h0C, 32'hA5A55A5A, 4'hF, 1, 1, 3, 2'b00, 0);
        do_read_seq("rd_after_rst", 6'h0C, 32'hA5A55A5A, 2'b00, 3, 0);
    endtask

    task automatic test_align();
`ifdef AXI4LITE_MASTER_ALIGN_CHECK_EN
        int aw0, w0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        send_cmd(1'b1, 6'h05, 32'h55AA55AA, 4'hF);
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, ARVALID, rsp_valid, cmd_ready} !== 5'b00010) begin
            errors++;
            $display("FAIL align_ctrl: got %b required 00010",
                     {AWVALID, WVALID, ARVALID, rsp_valid, cmd_ready});
        end
        finish_rsp("align_err", 1'b1, 32'h0, 2'b10, 1);
        checks++;
        if (aw_hs_cnt != aw0 || w_hs_cnt != w0) begin
            errors++;
            $display("FAIL align_no_bus: got aw_hs=%0d w_hs=%0d required 0 0",
                     aw_hs_cnt - aw0, w_hs_cnt - w0);
        end
`else
        do_write_seq("wr_unaligned", 6'h05, 32'h55AA55AA, 4'hF, 1, 1, 3, 2'b00, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_aw_w_skew();
        test_read_wait();
        test_slverr();
        test_strobe();
        test_reset_mid();
        test_align();
        repeat (2) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
